// File: rtl/button_events.sv
// button_events: turns a clean, clk-synchronous button level into one-cycle
// event pulses (press, release, long-press, auto-repeat) plus a held level.
// One instance per button, fed by that button's debouncer.
//
// The release and repeat events are exposed as release_pulse and
// repeat_pulse because "release" and "repeat" are reserved words in
// SystemVerilog and cannot be used as port names.
module button_events #(
    parameter bit ACTIVE_LOW    = 1'b0,      // 1: input level 0 means pressed
    parameter int HOLD_CYCLES   = 50000000,  // press pulse -> long_press pulse, >= 1
    parameter int REPEAT_CYCLES = 10000000,  // spacing of repeat pulses, >= 1
    parameter bit REPEAT_EN     = 1'b1       // 0: repeat_pulse never asserts
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic held,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    // The counter only ever needs to reach the larger of the two thresholds.
    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    // Normalised level: 1 always means "pressed" from here on.
    logic lvl;
    assign lvl = in ^ ACTIVE_LOW;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             lvl_q_reg;

    logic held_reg, held_next;
    logic press_reg, press_next;
    logic release_reg, release_next;
    logic long_reg, long_next;
    logic repeat_reg, repeat_next;

    // Next-state and next-output decode; every pulse defaults low.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Only a fresh edge counts: a level already high when we
                // came out of reset must be released first.
                if (lvl && !lvl_q_reg) begin
                    press_next = 1'b1;
                    state_next = PRESSED;
                    cnt_next   = '0;
                end
            end

            PRESSED: begin
                // Release wins over the long-press threshold.
                if (!lvl) begin
                    release_next = 1'b1;
                    state_next   = IDLE;
                    cnt_next     = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    long_next  = 1'b1;
                    state_next = REPEAT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            REPEAT: begin
                // Release wins over the repeat threshold; with repeats
                // disabled the counter simply stays at zero.
                if (!lvl) begin
                    release_next = 1'b1;
                    state_next   = IDLE;
                    cnt_next     = '0;
                end else if (REPEAT_EN) begin
                    if (cnt_reg == REPEAT_LAST) begin
                        repeat_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // held tracks the state we are about to enter, so it rises with
        // press and falls with release.
        held_next = (state_next != IDLE);
    end

    // State, counter, previous level and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            lvl_q_reg   <= lvl;
            held_reg    <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lvl_q_reg   <= lvl;
            held_reg    <= held_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            long_reg    <= long_next;
            repeat_reg  <= repeat_next;
        end
    end

    assign held          = held_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign long_press    = long_reg;
    assign repeat_pulse  = repeat_reg;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: three instances (active-high with
// repeat, active-low with repeat, active-high without repeat), all with
// HOLD=10 and REPEAT=4. Observations are taken 1 time unit after each
// rising edge; observation k after driving "in" reflects cycle t+k where t
// is the edge that first samples the new level.
`timescale 1ns/1ps
module tb_button_events;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_a = 1'b0;
    logic in_b = 1'b1;
    logic in_c = 1'b0;

    logic held_a, press_a, rel_a, long_a, rpt_a;
    logic held_b, press_b, rel_b, long_b, rpt_b;
    logic held_c, press_c, rel_c, long_c, rpt_c;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    // {held, press, release, long_press, repeat}
    logic [4:0] obs_a, obs_b, obs_c;
    assign obs_a = {held_a, press_a, rel_a, long_a, rpt_a};
    assign obs_b = {held_b, press_b, rel_b, long_b, rpt_b};
    assign obs_c = {held_c, press_c, rel_c, long_c, rpt_c};

    always #5 clk = ~clk;

    button_events #(.ACTIVE_LOW(1'b0), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .held(held_a), .press(press_a),
        .release_pulse(rel_a), .long_press(long_a), .repeat_pulse(rpt_a)
    );

    button_events #(.ACTIVE_LOW(1'b1), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .held(held_b), .press(press_b),
        .release_pulse(rel_b), .long_press(long_b), .repeat_pulse(rpt_b)
    );

    button_events #(.ACTIVE_LOW(1'b0), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .REPEAT_EN(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in(in_c), .held(held_c), .press(press_c),
        .release_pulse(rel_c), .long_press(long_c), .repeat_pulse(rpt_c)
    );

    // Pulses must be one-hot-or-zero on every cycle for every instance.
    always @(negedge clk) begin
        if (chk_en) begin
            assert ($onehot0({press_a, rel_a, long_a, rpt_a})) else begin
                miscompares++;
                $display("FAIL onehot_a t=%0t got=%b required one-hot-or-zero", $time, obs_a[3:0]);
            end
            assert ($onehot0({press_b, rel_b, long_b, rpt_b})) else begin
                miscompares++;
                $display("FAIL onehot_b t=%0t got=%b required one-hot-or-zero", $time, obs_b[3:0]);
            end
            assert ($onehot0({press_c, rel_c, long_c, rpt_c})) else begin
                miscompares++;
                $display("FAIL onehot_c t=%0t got=%b required one-hot-or-zero", $time, obs_c[3:0]);
            end
        end
    end

    task automatic test_reset();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if ({obs_a, obs_b, obs_c} !== 15'b0) begin
                miscompares++;
                $display("FAIL reset k=%0d got=%b/%b/%b required=00000", k, obs_a, obs_b, obs_c);
            end
        end
        chk_en = 1'b1;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if ({obs_a, obs_b, obs_c} !== 15'b0) begin
                miscompares++;
                $display("FAIL post_reset k=%0d got=%b/%b/%b required=00000", k, obs_a, obs_b, obs_c);
            end
        end
    endtask

    // Scenario 1: long press then repeats every 4; release lands on a repeat threshold.
    task automatic test_long_press();
        logic [4:0] exp;
        in_a = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            exp = {k <= 30, k == 1, k == 31, k == 11, (k == 15 || k == 19 || k == 23 || k == 27)};
            vectors++;
            if (obs_a !== exp) begin
                miscompares++;
                $display("FAIL long_press k=%0d got=%b required=%b", k, obs_a, exp);
            end
            if (k == 30) in_a = 1'b0;
        end
    endtask

    // Scenario 2: short press, no long_press.
    task automatic test_short_press();
        logic [4:0] exp;
        in_a = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            exp = {k <= 5, k == 1, k == 6, 1'b0, 1'b0};
            vectors++;
            if (obs_a !== exp) begin
                miscompares++;
                $display("FAIL short_press k=%0d got=%b required=%b", k, obs_a, exp);
            end
            if (k == 5) in_a = 1'b0;
        end
    endtask

    // Scenario 3: release sampled exactly when cnt == HOLD_CYCLES-1.
    task automatic test_release_at_threshold();
        logic [4:0] exp;
        in_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            exp = {k <= 10, k == 1, k == 11, 1'b0, 1'b0};
            vectors++;
            if (obs_a !== exp) begin
                miscompares++;
                $display("FAIL release_at_threshold k=%0d got=%b required=%b", k, obs_a, exp);
            end
            if (k == 10) in_a = 1'b0;
        end
    endtask

    // Scenario 4: active-low instance, same timing as the short press.
    task automatic test_active_low();
        logic [4:0] exp;
        in_b = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            exp = {k <= 5, k == 1, k == 6, 1'b0, 1'b0};
            vectors++;
            if (obs_b !== exp) begin
                miscompares++;
                $display("FAIL active_low k=%0d got=%b required=%b", k, obs_b, exp);
            end
            if (k == 5) in_b = 1'b1;
        end
    endtask

    // Scenario 5: button held across reset gives neither press nor release.
    task automatic test_held_through_reset();
        logic [4:0] exp;
        in_a = 1'b1;
        rst  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (obs_a !== 5'b0) begin
                miscompares++;
                $display("FAIL held_in_reset k=%0d got=%b required=00000", k, obs_a);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (obs_a !== 5'b0) begin
                miscompares++;
                $display("FAIL held_after_reset k=%0d got=%b required=00000", k, obs_a);
            end
        end
        in_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (obs_a !== 5'b0) begin
                miscompares++;
                $display("FAIL silent_release k=%0d got=%b required=00000", k, obs_a);
            end
        end
        in_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp = {k <= 4, k == 1, k == 5, 1'b0, 1'b0};
            vectors++;
            if (obs_a !== exp) begin
                miscompares++;
                $display("FAIL press_after_reset k=%0d got=%b required=%b", k, obs_a, exp);
            end
            if (k == 4) in_a = 1'b0;
        end
    endtask

    // Release then immediate re-press: IDLE needs only one cycle.
    task automatic test_back_to_back();
        logic [4:0] exp;
        in_a = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            exp = {(k <= 3) || (k >= 5 && k <= 16), (k == 1 || k == 5), (k == 4 || k == 17), k == 15, 1'b0};
            vectors++;
            if (obs_a !== exp) begin
                miscompares++;
                $display("FAIL back_to_back k=%0d got=%b required=%b", k, obs_a, exp);
            end
            if (k == 3)  in_a = 1'b0;
            if (k == 4)  in_a = 1'b1;
            if (k == 16) in_a = 1'b0;
        end
    endtask

    // Scenario 6: repeats disabled, long hold gives one press and one long_press.
    task automatic test_no_repeat();
        logic [4:0] exp;
        in_c = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            exp = {k <= 40, k == 1, k == 41, k == 11, 1'b0};
            vectors++;
            if (obs_c !== exp) begin
                miscompares++;
                $display("FAIL no_repeat k=%0d got=%b required=%b", k, obs_c, exp);
            end
            if (k == 40) in_c = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_long_press();
        test_short_press();
        test_release_at_threshold();
        test_active_low();
        test_held_through_reset();
        test_back_to_back();
        test_no_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog t=%0t bench did not finish, required finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
